// File: rtl/sw_poll_debounce_ctrl.sv
// Avalon-MM read master that periodically polls the switch PIO data register,
// debounces the samples and raises a single-entry change event for game logic.
module sw_poll_debounce_ctrl #(
  parameter int unsigned WIDTH            = 8,
  parameter int unsigned POLL_DIV         = 50000,
  parameter int unsigned DEBOUNCE_SAMPLES = 4,
  parameter int unsigned READ_LATENCY     = 1,
  parameter logic [1:0]  SW_ADDR          = 2'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [1:0]       avm_address,
  output logic             avm_read,
  input  logic [31:0]      avm_readdata,
  output logic [WIDTH-1:0] sw_state,
  output logic             chg_valid,
  output logic [WIDTH-1:0] chg_data,
  input  logic             chg_ready,
  output logic             overflow,
  input  logic             overflow_clr
);

  localparam int unsigned DIV_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, READ, WAIT, SAMPLE} state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div_cnt, div_nxt;
  logic [LAT_W-1:0]   lat_cnt, lat_nxt;
  logic [WIDTH-1:0]   cand, cand_nxt;
  logic [CNT_W-1:0]   stable_cnt, cnt_nxt;
  logic [WIDTH-1:0]   sw_nxt, data_nxt;
  logic               valid_nxt, ovf_nxt, read_nxt;
  logic [1:0]         addr_nxt;
  logic               tick, ev;
  logic [WIDTH-1:0]   sample;

  // Only the low WIDTH bits of the data register carry switch state.
  logic unused_rdata;
  assign unused_rdata = ^avm_readdata[31:WIDTH];

  assign sample = avm_readdata[WIDTH-1:0];
  assign tick   = enable && (div_cnt == DIV_W'(POLL_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      div_cnt     <= '0;
      lat_cnt     <= '0;
      cand        <= '0;
      stable_cnt  <= '0;
      sw_state    <= '0;
      chg_valid   <= 1'b0;
      chg_data    <= '0;
      overflow    <= 1'b0;
      avm_read    <= 1'b0;
      avm_address <= 2'd0;
    end else begin
      state       <= state_nxt;
      div_cnt     <= div_nxt;
      lat_cnt     <= lat_nxt;
      cand        <= cand_nxt;
      stable_cnt  <= cnt_nxt;
      sw_state    <= sw_nxt;
      chg_valid   <= valid_nxt;
      chg_data    <= data_nxt;
      overflow    <= ovf_nxt;
      avm_read    <= read_nxt;
      avm_address <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    cand_nxt  = cand;
    cnt_nxt   = stable_cnt;
    sw_nxt    = sw_state;
    valid_nxt = chg_valid;
    data_nxt  = chg_data;
    ovf_nxt   = overflow;
    ev        = 1'b0;

    if (!enable || tick) div_nxt = '0;
    else                 div_nxt = div_cnt + DIV_W'(1);

    case (state)
      IDLE: if (tick) state_nxt = READ;
      READ: begin
        state_nxt = WAIT;
        lat_nxt   = '0;
      end
      WAIT: begin
        if (lat_cnt == LAT_W'(READ_LATENCY - 1)) state_nxt = SAMPLE;
        else                                     lat_nxt   = lat_cnt + LAT_W'(1);
      end
      SAMPLE: begin
        // Counter saturates so a long-stable value keeps its accepted status.
        if (sample == cand) begin
          if (stable_cnt != CNT_W'(DEBOUNCE_SAMPLES)) cnt_nxt = stable_cnt + CNT_W'(1);
        end else begin
          cand_nxt = sample;
          cnt_nxt  = CNT_W'(1);
        end
        if (cnt_nxt == CNT_W'(DEBOUNCE_SAMPLES) && cand_nxt != sw_state) begin
          ev     = 1'b1;
          sw_nxt = cand_nxt;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A new event overrides a same-cycle accept; overflow set beats clear.
    if (chg_valid && chg_ready) valid_nxt = 1'b0;
    if (overflow_clr)           ovf_nxt   = 1'b0;
    if (ev) begin
      valid_nxt = 1'b1;
      data_nxt  = sw_nxt;
      if (chg_valid && !chg_ready) ovf_nxt = 1'b1;
    end

    read_nxt = (state_nxt == READ);
    addr_nxt = read_nxt ? SW_ADDR : 2'd0;
  end

endmodule

// File: tb/tb_sw_poll_debounce_ctrl.sv
// Bench for sw_poll_debounce_ctrl: per-poll vector table with a scoreboard queue,
// plus hand sequences for enable drop mid-read and reset mid-read.
module tb_sw_poll_debounce_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic [7:0]  sw_state;
  logic        chg_valid;
  logic [7:0]  chg_data;
  logic        chg_ready;
  logic        overflow;
  logic        overflow_clr;
  logic [7:0]  sw;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] sw;
    bit         rdy_s;
    bit         ack;
    bit         clr;
    logic [7:0] e_state;
    bit         e_valid;
    logic [7:0] e_data;
    bit         e_ovf;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  sw_poll_debounce_ctrl #(
    .WIDTH(8), .POLL_DIV(8), .DEBOUNCE_SAMPLES(3), .READ_LATENCY(1), .SW_ADDR(2'd0)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .sw_state(sw_state), .chg_valid(chg_valid), .chg_data(chg_data),
    .chg_ready(chg_ready), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered slave: data valid the cycle after the read strobe, then held.
  always @(posedge clk) if (avm_read) avm_readdata <= {24'h0, sw};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_read(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (avm_read) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL read_timeout: got no avm_read expected a poll within 20 cycles");
    end
  endtask

  task automatic add(input logic [7:0] s, input bit rs, input bit a, input bit c,
                     input logic [7:0] es, input bit ev, input logic [7:0] ed, input bit eo);
    vec_t v;
    v.sw = s; v.rdy_s = rs; v.ack = a; v.clr = c;
    v.e_state = es; v.e_valid = ev; v.e_data = ed; v.e_ovf = eo;
    vecs.push_back(v);
  endtask

  task automatic check_outs(input string tag, input vec_t e);
    chk({tag, "_sw_state"},  32'(sw_state),  32'(e.e_state));
    chk({tag, "_chg_valid"}, 32'(chg_valid), 32'(e.e_valid));
    chk({tag, "_chg_data"},  32'(chg_data),  32'(e.e_data));
    chk({tag, "_overflow"},  32'(overflow),  32'(e.e_ovf));
  endtask

  task automatic run_row(input vec_t v, input int idx, inout int prev_cyc);
    bit   ok;
    vec_t e;
    sw = v.sw;
    sb.push_back(v);
    wait_read(ok);
    if (!ok) return;
    chk($sformatf("row%0d_addr", idx), 32'(avm_address), 32'd0);
    if (prev_cyc >= 0) chk($sformatf("row%0d_period", idx), 32'(cyc - prev_cyc), 32'd8);
    prev_cyc = cyc;
    @(negedge clk);
    chk($sformatf("row%0d_read_width", idx), 32'(avm_read), 32'd0);
    @(negedge clk);
    if (v.rdy_s) begin
      chk($sformatf("row%0d_valid_before", idx), 32'(chg_valid), 32'd1);
      chg_ready = 1'b1;
    end
    @(negedge clk);
    chg_ready = 1'b0;
    e = sb.pop_front();
    check_outs($sformatf("row%0d", idx), e);
    if (v.ack || v.clr) begin
      chg_ready    = v.ack;
      overflow_clr = v.clr;
      @(negedge clk);
      chg_ready    = 1'b0;
      overflow_clr = 1'b0;
      if (v.ack) chk($sformatf("row%0d_ack_clears", idx), 32'(chg_valid), 32'd0);
    end
  endtask

  task automatic poll_and_check(input string tag, input vec_t e);
    bit ok;
    wait_read(ok);
    if (!ok) return;
    repeat (3) @(negedge clk);
    check_outs(tag, e);
  endtask

  initial begin
    int   prev_cyc;
    int   nreads;
    vec_t e;

    reset = 1'b1; enable = 1'b1; chg_ready = 1'b0; overflow_clr = 1'b0; sw = 8'h00;
    avm_readdata = 32'h0;

    // Idle switches: no events.
    for (int i = 0; i < 3; i++) add(8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0);
    // Clean change to A5, accepted on the third sample.
    add(8'hA5, 0, 0, 0, 8'h00, 0, 8'h00, 0);
    add(8'hA5, 0, 0, 0, 8'h00, 0, 8'h00, 0);
    add(8'hA5, 0, 1, 0, 8'hA5, 1, 8'hA5, 0);
    // Bounce then stable 01: single event.
    add(8'h00, 0, 0, 0, 8'hA5, 0, 8'hA5, 0);
    add(8'h01, 0, 0, 0, 8'hA5, 0, 8'hA5, 0);
    add(8'h00, 0, 0, 0, 8'hA5, 0, 8'hA5, 0);
    add(8'h01, 0, 0, 0, 8'hA5, 0, 8'hA5, 0);
    add(8'h01, 0, 0, 0, 8'hA5, 0, 8'hA5, 0);
    add(8'h01, 0, 1, 0, 8'h01, 1, 8'h01, 0);
    // Unaccepted event overwritten: overflow, then cleared.
    add(8'h00, 0, 0, 0, 8'h01, 0, 8'h01, 0);
    add(8'h00, 0, 0, 0, 8'h01, 0, 8'h01, 0);
    add(8'h00, 0, 0, 0, 8'h00, 1, 8'h00, 0);
    add(8'h03, 0, 0, 0, 8'h00, 1, 8'h00, 0);
    add(8'h03, 0, 0, 0, 8'h00, 1, 8'h00, 0);
    add(8'h03, 0, 0, 1, 8'h03, 1, 8'h03, 1);
    // Accept coinciding with a new event: no gap, no overflow.
    add(8'h07, 0, 0, 0, 8'h03, 1, 8'h03, 0);
    add(8'h07, 0, 0, 0, 8'h03, 1, 8'h03, 0);
    add(8'h07, 1, 1, 0, 8'h07, 1, 8'h07, 0);

    @(negedge clk);
    chk("reset_avm_read", 32'(avm_read), 32'd0);
    chk("reset_avm_address", 32'(avm_address), 32'd0);
    e = '{sw: 8'h00, rdy_s: 0, ack: 0, clr: 0, e_state: 8'h00, e_valid: 0, e_data: 8'h00, e_ovf: 0};
    check_outs("reset", e);
    reset = 1'b0;

    prev_cyc = -1;
    foreach (vecs[i]) run_row(vecs[i], i, prev_cyc);

    // Enable dropped during WAIT: the in-flight sample still counts.
    begin
      bit ok;
      sw = 8'h0F;
      wait_read(ok);
      @(negedge clk);
      enable = 1'b0;
      nreads = 0;
      repeat (30) begin
        @(negedge clk);
        if (avm_read) nreads++;
      end
      chk("disabled_no_reads", 32'(nreads), 32'd0);
      enable = 1'b1;
      e = '{sw: 8'h0F, rdy_s: 0, ack: 0, clr: 0, e_state: 8'h07, e_valid: 0, e_data: 8'h07, e_ovf: 0};
      poll_and_check("reen1", e);
      e = '{sw: 8'h0F, rdy_s: 0, ack: 0, clr: 0, e_state: 8'h0F, e_valid: 1, e_data: 8'h0F, e_ovf: 0};
      poll_and_check("reen2", e);
    end

    // Reset during READ: outputs clear immediately.
    begin
      bit ok;
      wait_read(ok);
      reset = 1'b1;
      #1;
      chk("rst_mid_avm_read", 32'(avm_read), 32'd0);
      chk("rst_mid_avm_address", 32'(avm_address), 32'd0);
      e = '{sw: 8'h0F, rdy_s: 0, ack: 0, clr: 0, e_state: 8'h00, e_valid: 0, e_data: 8'h00, e_ovf: 0};
      check_outs("rst_mid", e);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      poll_and_check("post_rst1", e);
      poll_and_check("post_rst2", e);
      e = '{sw: 8'h0F, rdy_s: 0, ack: 0, clr: 0, e_state: 8'h0F, e_valid: 1, e_data: 8'h0F, e_ovf: 0};
      poll_and_check("post_rst3", e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
